// File: rtl/period_sampler.sv
// Oscillator period meter: sums CLK cycles over 2^EDGES_LOG2 rising edges of FREQ_IN
// and strobes each completed sum out; flags a dead oscillator after a long edge gap.
module period_sampler #(
    parameter int DATA_BITS    = 28,
    parameter int EDGES_LOG2   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 FREQ_IN,
    output logic [DATA_BITS-1:0] OUT_VALUE,
    output logic                 OUT_VALID,
    output logic                 TIMEOUT
);

    localparam int EW = (EDGES_LOG2 < 1) ? 1 : EDGES_LOG2;
    localparam logic [EW-1:0]           ECNT_LAST = EW'((1 << EDGES_LOG2) - 1);
    localparam logic [DATA_BITS-1:0]    CNT_MAX   = '1;
    localparam logic [TIMEOUT_BITS-1:0] IDLE_MAX  = '1;
    // One below the limit: the increment about to land on the limit is what trips the timeout.
    localparam logic [TIMEOUT_BITS-1:0] IDLE_TRIP = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

    typedef enum logic {IDLE, MEASURE} state_t;

    logic [SYNC_STAGES-1:0]  sync;
    logic                    hist;
    logic                    edge_e;
    logic [TIMEOUT_BITS-1:0] idle;
    logic                    timeout_hit;
    state_t                  state, state_n;
    logic [DATA_BITS-1:0]    cnt, cnt_n, cnt_inc;
    logic [EW-1:0]           ecnt, ecnt_n;
    logic [DATA_BITS-1:0]    value_n;
    logic                    valid_n;
    logic                    timeout_n;

    assign edge_e      = sync[SYNC_STAGES-1] & ~hist;
    assign timeout_hit = ~edge_e & (idle >= IDLE_TRIP);
    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + DATA_BITS'(1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync <= '0;
            hist <= 1'b0;
            idle <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], FREQ_IN};
            hist <= sync[SYNC_STAGES-1];
            if (edge_e)
                idle <= '0;
            else if (idle != IDLE_MAX)
                idle <= idle + TIMEOUT_BITS'(1);
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ecnt_n    = ecnt;
        value_n   = OUT_VALUE;
        valid_n   = 1'b0;
        timeout_n = TIMEOUT;
        if (edge_e)
            timeout_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n  = '0;
                ecnt_n = '0;
                if (edge_e) begin
                    cnt_n   = DATA_BITS'(1);
                    state_n = MEASURE;
                end
            end
            MEASURE: begin
                cnt_n = cnt_inc;
                if (edge_e) begin
                    if (ecnt == ECNT_LAST) begin
                        // Window end doubles as the first edge of the next window.
                        value_n = cnt;
                        valid_n = 1'b1;
                        cnt_n   = DATA_BITS'(1);
                        ecnt_n  = '0;
                    end else begin
                        ecnt_n = ecnt + EW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout_hit) begin
            timeout_n = 1'b1;
            state_n   = IDLE;
            cnt_n     = '0;
            ecnt_n    = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            ecnt      <= '0;
            OUT_VALUE <= '0;
            OUT_VALID <= 1'b0;
            TIMEOUT   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ecnt      <= ecnt_n;
            OUT_VALUE <= value_n;
            OUT_VALID <= valid_n;
            TIMEOUT   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_period_sampler.sv
// Bench for period_sampler: per-cycle comparison against an edge-timestamp model,
// plus directed checks of the headline numbers (40, 52, 46, 63, timeout timing).
module tb_period_sampler;
    localparam int DB = 6, EL = 2, SS = 2, TB = 6;
    localparam int TMAX = (1 << TB) - 1, CMAX = (1 << DB) - 1, WIN = 1 << EL;

    logic          CLK = 1'b0, RESET = 1'b1, FREQ_IN = 1'b0;
    logic [DB-1:0] OUT_VALUE;
    logic          OUT_VALID, TIMEOUT;
    int            checks = 0, passes = 0;

    period_sampler #(.DATA_BITS(DB), .EDGES_LOG2(EL), .SYNC_STAGES(SS), .TIMEOUT_BITS(TB)) dut (
        .CLK(CLK), .RESET(RESET), .FREQ_IN(FREQ_IN),
        .OUT_VALUE(OUT_VALUE), .OUT_VALID(OUT_VALID), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    // Model: levels sampled per clock since reset; an edge sampled at n is acted on at n+SS.
    bit lv[0:65535];
    int n, last_e, last_rise, t0, ecount, m_val;
    bit armed, m_vld, m_to;
    bit wq[$];
    int got[$];

    function automatic bit lvl_at(int m);
        return (m >= 1) ? lv[m] : 1'b0;
    endfunction

    function automatic void push_wave(int hi, int lo, int periods);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < hi; i++) wq.push_back(1'b1);
            for (int i = 0; i < lo; i++) wq.push_back(1'b0);
        end
    endfunction

    task automatic drive(input bit lvl);
        bit e;
        FREQ_IN = lvl;
        @(posedge CLK);
        n++;
        lv[n] = lvl;
        if (lvl && !lvl_at(n - 1)) last_rise = n;
        e = lvl_at(n - SS) && !lvl_at(n - SS - 1);
        m_vld = 1'b0;
        if (e) begin
            last_e = n;
            m_to   = 1'b0;
            if (!armed) begin
                armed = 1'b1; t0 = n; ecount = 0;
            end else begin
                ecount++;
                if (ecount == WIN) begin
                    m_val = (n - t0 > CMAX) ? CMAX : n - t0;
                    m_vld = 1'b1; t0 = n; ecount = 0;
                end
            end
        end else if (n - last_e >= TMAX) begin
            m_to = 1'b1; armed = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset;
        RESET = 1'b1;
        @(posedge CLK);
        n = 0; last_e = 0; last_rise = -1000; armed = 1'b0;
        m_val = 0; m_vld = 1'b0; m_to = 1'b0;
        #1;
        RESET = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b1; FREQ_IN = 1'b0;
        repeat (3) @(posedge CLK);
        do_reset();
        checks++;
        if (OUT_VALUE !== '0 || OUT_VALID !== 1'b0 || TIMEOUT !== 1'b0)
            $display("FAIL reset_state got val=%0d vld=%0b to=%0b want 0/0/0", OUT_VALUE, OUT_VALID, TIMEOUT);
        else passes++;
        wq = {}; push_wave(0, 10, 1);
        foreach (wq[i]) begin
            drive(wq[i]);
            checks++;
            if ({OUT_VALID, OUT_VALUE, TIMEOUT} !== {m_vld, DB'(m_val), m_to})
                $display("FAIL reset_idle n=%0d got vld=%0b val=%0d to=%0b want vld=%0b val=%0d to=%0b",
                         n, OUT_VALID, OUT_VALUE, TIMEOUT, m_vld, m_val, m_to);
            else passes++;
        end
    endtask

    task automatic test_steady;
        int first_v = -1;
        do_reset();
        got = {}; wq = {}; push_wave(5, 5, 12);
        foreach (wq[i]) begin
            drive(wq[i]);
            checks++;
            if ({OUT_VALID, OUT_VALUE, TIMEOUT} !== {m_vld, DB'(m_val), m_to})
                $display("FAIL steady n=%0d got vld=%0b val=%0d to=%0b want vld=%0b val=%0d to=%0b",
                         n, OUT_VALID, OUT_VALUE, TIMEOUT, m_vld, m_val, m_to);
            else passes++;
            if (OUT_VALID) begin
                got.push_back(int'(OUT_VALUE));
                if (first_v < 0) first_v = n;
            end
        end
        checks++;
        if (got.size() != 2 || got[0] != 40 || got[1] != 40)
            $display("FAIL steady_values got count=%0d first=%0d want 2 samples of 40", got.size(),
                     (got.size() > 0) ? got[0] : -1);
        else passes++;
        checks++;
        if (first_v != 1 + SS + 40)
            $display("FAIL steady_latency got n=%0d want n=%0d", first_v, 1 + SS + 40);
        else passes++;
    endtask

    task automatic test_period_change;
        got = {}; wq = {};
        push_wave(7, 6, 10);
        push_wave(5, 5, 7);
        foreach (wq[i]) begin
            drive(wq[i]);
            checks++;
            if ({OUT_VALID, OUT_VALUE, TIMEOUT} !== {m_vld, DB'(m_val), m_to})
                $display("FAIL period_change n=%0d got vld=%0b val=%0d to=%0b want vld=%0b val=%0d to=%0b",
                         n, OUT_VALID, OUT_VALUE, TIMEOUT, m_vld, m_val, m_to);
            else passes++;
            if (OUT_VALID) got.push_back(int'(OUT_VALUE));
        end
        checks++;
        if (got.size() != 5 || got[0] != 40 || got[1] != 52 || got[2] != 52 || got[3] != 46 || got[4] != 40)
            $display("FAIL period_change_seq got count=%0d want 40,52,52,46,40", got.size());
        else passes++;
    endtask

    task automatic test_timeout;
        int rise_n = -1, clr_n = -1, v_n = -1, v_val = -1;
        bit prev_to;
        wq = {}; push_wave(0, 80, 1);
        prev_to = TIMEOUT;
        foreach (wq[i]) begin
            drive(wq[i]);
            checks++;
            if ({OUT_VALID, OUT_VALUE, TIMEOUT} !== {m_vld, DB'(m_val), m_to})
                $display("FAIL timeout n=%0d got vld=%0b val=%0d to=%0b want vld=%0b val=%0d to=%0b",
                         n, OUT_VALID, OUT_VALUE, TIMEOUT, m_vld, m_val, m_to);
            else passes++;
            if (TIMEOUT === 1'b1 && !prev_to && rise_n < 0) rise_n = n;
            prev_to = (TIMEOUT === 1'b1);
        end
        checks++;
        if (rise_n - last_rise != TMAX + SS || OUT_VALUE !== DB'(40) || TIMEOUT !== 1'b1)
            $display("FAIL timeout_rise got delay=%0d val=%0d to=%0b want delay=%0d val=40 to=1",
                     rise_n - last_rise, OUT_VALUE, TIMEOUT, TMAX + SS);
        else passes++;
        wq = {}; push_wave(5, 5, 6);
        foreach (wq[i]) begin
            drive(wq[i]);
            checks++;
            if ({OUT_VALID, OUT_VALUE, TIMEOUT} !== {m_vld, DB'(m_val), m_to})
                $display("FAIL restart n=%0d got vld=%0b val=%0d to=%0b want vld=%0b val=%0d to=%0b",
                         n, OUT_VALID, OUT_VALUE, TIMEOUT, m_vld, m_val, m_to);
            else passes++;
            if (TIMEOUT === 1'b0 && clr_n < 0) clr_n = n;
            if (OUT_VALID === 1'b1 && v_n < 0) begin v_n = n; v_val = int'(OUT_VALUE); end
        end
        checks++;
        if (clr_n < 0 || v_n - clr_n != 40 || v_val != 40)
            $display("FAIL restart_window got clr=%0d gap=%0d val=%0d want gap=40 val=40", clr_n, v_n - clr_n, v_val);
        else passes++;
    endtask

    task automatic test_saturation;
        do_reset();
        got = {}; wq = {}; push_wave(10, 10, 6);
        foreach (wq[i]) begin
            drive(wq[i]);
            checks++;
            if ({OUT_VALID, OUT_VALUE, TIMEOUT} !== {m_vld, DB'(m_val), m_to})
                $display("FAIL saturation n=%0d got vld=%0b val=%0d to=%0b want vld=%0b val=%0d to=%0b",
                         n, OUT_VALID, OUT_VALUE, TIMEOUT, m_vld, m_val, m_to);
            else passes++;
            if (OUT_VALID) got.push_back(int'(OUT_VALUE));
        end
        checks++;
        if (got.size() != 1 || got[0] != 63)
            $display("FAIL saturation_value got count=%0d first=%0d want one sample of 63", got.size(),
                     (got.size() > 0) ? got[0] : -1);
        else passes++;
    endtask

    task automatic test_reset_mid;
        int v_n = -1, v_val = -1;
        wq = {}; push_wave(10, 10, 1);
        foreach (wq[i]) drive(wq[i]);
        do_reset();
        checks++;
        if (OUT_VALUE !== '0 || OUT_VALID !== 1'b0 || TIMEOUT !== 1'b0)
            $display("FAIL reset_mid got val=%0d vld=%0b to=%0b want 0/0/0", OUT_VALUE, OUT_VALID, TIMEOUT);
        else passes++;
        wq = {}; push_wave(5, 5, 6);
        foreach (wq[i]) begin
            drive(wq[i]);
            checks++;
            if ({OUT_VALID, OUT_VALUE, TIMEOUT} !== {m_vld, DB'(m_val), m_to})
                $display("FAIL reset_rearm n=%0d got vld=%0b val=%0d to=%0b want vld=%0b val=%0d to=%0b",
                         n, OUT_VALID, OUT_VALUE, TIMEOUT, m_vld, m_val, m_to);
            else passes++;
            if (OUT_VALID === 1'b1 && v_n < 0) begin v_n = n; v_val = int'(OUT_VALUE); end
        end
        checks++;
        if (v_n != 1 + SS + 40 || v_val != 40)
            $display("FAIL reset_rearm_first got n=%0d val=%0d want n=%0d val=40", v_n, v_val, 1 + SS + 40);
        else passes++;
    endtask

    task automatic test_tie;
        bit saw_to = 1'b0;
        do_reset();
        got = {}; wq = {}; push_wave(31, 32, 6);
        foreach (wq[i]) begin
            drive(wq[i]);
            checks++;
            if ({OUT_VALID, OUT_VALUE, TIMEOUT} !== {m_vld, DB'(m_val), m_to})
                $display("FAIL tie n=%0d got vld=%0b val=%0d to=%0b want vld=%0b val=%0d to=%0b",
                         n, OUT_VALID, OUT_VALUE, TIMEOUT, m_vld, m_val, m_to);
            else passes++;
            if (TIMEOUT !== 1'b0) saw_to = 1'b1;
            if (OUT_VALID) got.push_back(int'(OUT_VALUE));
        end
        checks++;
        if (saw_to || got.size() != 1 || got[0] != 63)
            $display("FAIL tie_no_timeout got to_seen=%0b count=%0d want to_seen=0 one sample of 63", saw_to, got.size());
        else passes++;
        // One cycle longer than the tie: the timeout must now fire.
        wq = {}; push_wave(31, 33, 1); push_wave(31, 32, 1);
        foreach (wq[i]) begin
            drive(wq[i]);
            checks++;
            if ({OUT_VALID, OUT_VALUE, TIMEOUT} !== {m_vld, DB'(m_val), m_to})
                $display("FAIL gap64 n=%0d got vld=%0b val=%0d to=%0b want vld=%0b val=%0d to=%0b",
                         n, OUT_VALID, OUT_VALUE, TIMEOUT, m_vld, m_val, m_to);
            else passes++;
            if (TIMEOUT === 1'b1) saw_to = 1'b1;
        end
        checks++;
        if (!saw_to)
            $display("FAIL gap64_timeout got to_seen=0 want to_seen=1");
        else passes++;
    endtask

    task automatic test_random;
        int hi, lo;
        do_reset();
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(24, 0) == 0) begin
                do_reset();
                checks++;
                if (OUT_VALUE !== '0 || OUT_VALID !== 1'b0 || TIMEOUT !== 1'b0)
                    $display("FAIL rand_reset got val=%0d vld=%0b to=%0b want 0/0/0", OUT_VALUE, OUT_VALID, TIMEOUT);
                else passes++;
            end
            hi = $urandom_range(30, 2);
            lo = ($urandom_range(9, 0) == 0) ? $urandom_range(75, 55) : $urandom_range(30, 2);
            wq = {}; push_wave(hi, lo, 1);
            foreach (wq[i]) begin
                drive(wq[i]);
                checks++;
                if ({OUT_VALID, OUT_VALUE, TIMEOUT} !== {m_vld, DB'(m_val), m_to})
                    $display("FAIL random n=%0d got vld=%0b val=%0d to=%0b want vld=%0b val=%0d to=%0b",
                             n, OUT_VALID, OUT_VALUE, TIMEOUT, m_vld, m_val, m_to);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_steady();
        test_period_change();
        test_timeout();
        test_saturation();
        test_reset_mid();
        test_tie();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
